// File: rtl/spike_rate_decoder.sv
// Windowed spike-rate decoder: counts spikes over WINDOW_CYCLES clocks, presents the count on a valid/ready port.
// Optional SPIKE_ISI_EN adds out_isi_min, the minimum inter-spike interval seen inside each window.
module spike_rate_decoder #(
  parameter int unsigned WINDOW_CYCLES = 16,
  parameter int unsigned COUNT_W       = 8
`ifdef SPIKE_ISI_EN
  ,
  parameter int unsigned ISI_W         = 8
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               spike_in,
  input  logic               enable,
  input  logic               clear,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               overrun
`ifdef SPIKE_ISI_EN
  ,
  output logic [ISI_W-1:0]   out_isi_min
`endif
);

  localparam int unsigned WIN_W = $clog2(WINDOW_CYCLES);

  typedef enum logic [0:0] {IDLE, COUNT} state_t;

  state_t             state_q, state_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [COUNT_W-1:0] acc_q, acc_d, acc_inc;
  logic [COUNT_W-1:0] count_d;
  logic               valid_d, overrun_d;
  logic               win_close, res_load;

  // The closing sample is folded in, so the result is the saturated acc including this edge's spike.
  assign acc_inc   = (spike_in && (acc_q != '1)) ? acc_q + COUNT_W'(1) : acc_q;
  assign win_close = enable && (win_q == WIN_W'(WINDOW_CYCLES - 1));
  assign res_load  = win_close && !clear && (!out_valid || out_ready);

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    acc_d     = acc_q;
    count_d   = out_count;
    valid_d   = out_valid;
    overrun_d = overrun;

    unique case (state_q)
      IDLE:    if (enable)  state_d = COUNT;
      COUNT:   if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (clear) begin
      win_d     = '0;
      acc_d     = '0;
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end else begin
      // Window position and accumulator only advance on enabled edges; otherwise they hold.
      if (enable) begin
        if (win_close) begin
          win_d = '0;
          acc_d = '0;
        end else begin
          win_d = win_q + WIN_W'(1);
          acc_d = acc_inc;
        end
      end

      if (res_load) begin
        count_d = acc_inc;
        valid_d = 1'b1;
      end else if (win_close) begin
        overrun_d = 1'b1;
      end else if (out_valid && out_ready) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      win_q     <= '0;
      acc_q     <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      acc_q     <= acc_d;
      out_count <= count_d;
      out_valid <= valid_d;
      overrun   <= overrun_d;
    end
  end

`ifdef SPIKE_ISI_EN
  logic [ISI_W-1:0] gap_q, gap_d, gap_inc;
  logic [ISI_W-1:0] isi_q, isi_d, isi_cand;
  logic [ISI_W-1:0] out_isi_d;
  logic             seen_q, seen_d;

  // gap_q counts enabled clocks since the last spike; a spike closes a spacing of gap_q+1.
  always_comb begin
    gap_inc   = (gap_q == '1) ? gap_q : gap_q + ISI_W'(1);
    isi_cand  = isi_q;
    gap_d     = gap_q;
    isi_d     = isi_q;
    seen_d    = seen_q;
    out_isi_d = out_isi_min;

    if (spike_in && seen_q && (gap_inc < isi_q)) isi_cand = gap_inc;

    if (clear) begin
      gap_d  = '0;
      isi_d  = '1;
      seen_d = 1'b0;
    end else if (enable) begin
      if (win_close) begin
        gap_d  = '0;
        isi_d  = '1;
        seen_d = 1'b0;
      end else begin
        gap_d  = spike_in ? '0 : gap_inc;
        isi_d  = isi_cand;
        seen_d = seen_q | spike_in;
      end
      if (res_load) out_isi_d = isi_cand;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q       <= '0;
      isi_q       <= '1;
      seen_q      <= 1'b0;
      out_isi_min <= '1;
    end else begin
      gap_q       <= gap_d;
      isi_q       <= isi_d;
      seen_q      <= seen_d;
      out_isi_min <= out_isi_d;
    end
  end
`endif

endmodule
